// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues instruction memory reads,
// handles redirects from decode (including one that arrives while a fetch
// miss is still in flight) and presents the registered IF/ID latch.
module fetch_stage #(
   parameter logic [31:0] PC_INIT = 32'h00000000
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic [1:0]  pc_sel,
   input  logic [31:0] brAddr,
   input  logic [31:0] jAddr,
   input  logic [31:0] jrAddr,
   input  logic        stall,
   input  logic        halt,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_imemAddr
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } fetchState_t;

   fetchState_t stateReg;
   logic [31:0] pcReg;
   logic [31:0] pendingReg;
   logic        renReg;
   logic        validReg;
   logic [31:0] instrReg;
   logic [31:0] ifPcReg;
   logic [31:0] ifAddrReg;

   logic        redirect;
   logic [31:0] redirTarget;
   logic [31:0] pcPlus4;

   // Select the redirect target; targets are always word aligned.
   always_comb begin
      redirTarget = 32'h0;
      unique case (pc_sel)
         2'b01:   redirTarget = {brAddr[31:2], 2'b00};
         2'b10:   redirTarget = {jAddr[31:2], 2'b00};
         2'b11:   redirTarget = {jrAddr[31:2], 2'b00};
         default: redirTarget = 32'h0;
      endcase
   end

   assign redirect = (pc_sel != 2'b00);
   assign pcPlus4  = pcReg + 32'd4;   // wraps naturally at 2^32

   // Fetch FSM with PC, pending redirect and IF/ID latch as registered outputs.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stateReg   <= FETCH;
         pcReg      <= PC_INIT;
         pendingReg <= 32'h0;
         renReg     <= 1'b1;
         validReg   <= 1'b0;
         instrReg   <= 32'h0;
         ifPcReg    <= 32'h0;
         ifAddrReg  <= 32'h0;
      end else begin
         unique case (stateReg)
            FETCH: begin
               if (halt) begin
                  stateReg <= HALTED;
                  renReg   <= 1'b0;
                  validReg <= 1'b0;
               end else if (redirect) begin
                  validReg <= 1'b0;
                  if (ihit) begin
                     pcReg <= redirTarget;
                  end else begin
                     // Read still outstanding on the old PC: let it finish first.
                     pendingReg <= redirTarget;
                     stateReg   <= DRAIN;
                  end
               end else if (stall) begin
                  // Hazard hold: PC and latch keep their contents.
               end else if (ihit) begin
                  pcReg     <= pcPlus4;
                  instrReg  <= imemload;
                  ifAddrReg <= pcReg;
                  ifPcReg   <= pcPlus4;
                  validReg  <= 1'b1;
               end else begin
                  validReg <= 1'b0;
               end
            end
            DRAIN: begin
               validReg <= 1'b0;
               if (halt) begin
                  stateReg <= HALTED;
                  renReg   <= 1'b0;
               end else if (redirect && ihit) begin
                  // Newest redirect wins and the stale word is dropped.
                  pcReg    <= redirTarget;
                  stateReg <= FETCH;
               end else if (redirect) begin
                  pendingReg <= redirTarget;
               end else if (ihit) begin
                  pcReg    <= pendingReg;
                  stateReg <= FETCH;
               end
            end
            HALTED: begin
               renReg   <= 1'b0;
               validReg <= 1'b0;
            end
            default: begin
               stateReg <= FETCH;
               renReg   <= 1'b1;
               validReg <= 1'b0;
            end
         endcase
      end
   end

   assign imemREN     = renReg;
   assign imemaddr    = pcReg;
   assign if_valid    = validReg;
   assign if_instr    = instrReg;
   assign if_pc       = ifPcReg;
   assign if_imemAddr = ifAddrReg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, misses, redirects with
// and without a miss in flight, stall hold, PC wrap and halt/reset.
module tb_fetch_stage;

   logic        CLK;
   logic        nRST;
   logic        ihit;
   logic [31:0] imemload;
   logic [1:0]  pc_sel;
   logic [31:0] brAddr, jAddr, jrAddr;
   logic        stall, halt;

   logic        imemREN, if_valid;
   logic [31:0] imemaddr, if_instr, if_pc, if_imemAddr;

   logic        imemREN2, if_valid2;
   logic [31:0] imemaddr2, if_instr2, if_pc2, if_imemAddr2;

   int cmpCount = 0;
   int errCount = 0;

   fetch_stage #(.PC_INIT(32'h00000000)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
      .imemREN(imemREN), .imemaddr(imemaddr), .pc_sel(pc_sel),
      .brAddr(brAddr), .jAddr(jAddr), .jrAddr(jrAddr),
      .stall(stall), .halt(halt), .if_valid(if_valid),
      .if_instr(if_instr), .if_pc(if_pc), .if_imemAddr(if_imemAddr)
   );

   fetch_stage #(.PC_INIT(32'hFFFFFFFC)) dutWrap (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
      .imemREN(imemREN2), .imemaddr(imemaddr2), .pc_sel(pc_sel),
      .brAddr(brAddr), .jAddr(jAddr), .jrAddr(jrAddr),
      .stall(stall), .halt(halt), .if_valid(if_valid2),
      .if_instr(if_instr2), .if_pc(if_pc2), .if_imemAddr(if_imemAddr2)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Instruction memory model: each word is tagged with its own address.
   function automatic logic [31:0] memTag(input logic [31:0] a);
      return a ^ 32'hA5A50000;
   endfunction

   assign imemload = memTag(imemaddr);

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmpCount++;
      if (obs !== exp) begin
         errCount++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("ok   %s: %h", tag, obs);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic setIn(input logic h, input logic [1:0] sel, input logic st, input logic hl);
      ihit   = h;
      pc_sel = sel;
      stall  = st;
      halt   = hl;
   endtask

   initial begin
      nRST = 1'b0;
      setIn(1'b0, 2'b00, 1'b0, 1'b0);
      brAddr = 32'h0; jAddr = 32'h0; jrAddr = 32'h0;
      #12;
      // Reset state
      checkVal("rst_valid", {31'h0, if_valid}, 32'h0);
      checkVal("rst_instr", if_instr, 32'h0);
      checkVal("rst_ifpc", if_pc, 32'h0);
      checkVal("rst_addr", imemaddr, 32'h0);
      checkVal("rst_ren", {31'h0, imemREN}, 32'h1);
      checkVal("rst_wrap_addr", imemaddr2, 32'hFFFFFFFC);

      // Sequential fetch with ihit every cycle
      @(posedge CLK); #1;
      nRST = 1'b1;
      setIn(1'b1, 2'b00, 1'b0, 1'b0);
      step();
      checkVal("seq0_valid", {31'h0, if_valid}, 32'h1);
      checkVal("seq0_addr", if_imemAddr, 32'h0);
      checkVal("seq0_pc", if_pc, 32'h4);
      checkVal("seq0_instr", if_instr, 32'hA5A50000);
      checkVal("wrap_second_fetch", imemaddr2, 32'h00000000);
      step();
      checkVal("seq1_addr", if_imemAddr, 32'h4);
      checkVal("seq1_pc", if_pc, 32'h8);
      step();
      checkVal("seq2_addr", if_imemAddr, 32'h8);
      checkVal("seq2_pc", if_pc, 32'hC);
      step();
      checkVal("seq3_imemaddr", imemaddr, 32'h10);

      // Three-cycle miss at 0x10
      setIn(1'b0, 2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         checkVal($sformatf("miss%0d_addr", i), imemaddr, 32'h10);
         checkVal($sformatf("miss%0d_valid", i), {31'h0, if_valid}, 32'h0);
      end
      setIn(1'b1, 2'b00, 1'b0, 1'b0);
      step();
      checkVal("miss_done_valid", {31'h0, if_valid}, 32'h1);
      checkVal("miss_done_addr", if_imemAddr, 32'h10);
      checkVal("miss_done_instr", if_instr, memTag(32'h10));
      checkVal("miss_done_pc", imemaddr, 32'h14);

      // Jump with ihit: immediate redirect to 0x40, bubble
      jAddr = 32'h00000040;
      setIn(1'b1, 2'b10, 1'b0, 1'b0);
      step();
      checkVal("jmp_pc", imemaddr, 32'h40);
      checkVal("jmp_valid", {31'h0, if_valid}, 32'h0);

      // Branch during miss: DRAIN, target 0x203 aligned to 0x200
      brAddr = 32'h00000203;
      setIn(1'b0, 2'b01, 1'b0, 1'b0);
      step();
      checkVal("drain_addr", imemaddr, 32'h40);
      checkVal("drain_ren", {31'h0, imemREN}, 32'h1);
      checkVal("drain_valid", {31'h0, if_valid}, 32'h0);
      setIn(1'b0, 2'b00, 1'b0, 1'b0);
      step();
      checkVal("drain_hold_addr", imemaddr, 32'h40);
      setIn(1'b1, 2'b00, 1'b0, 1'b0);
      step();
      checkVal("drain_exit_pc", imemaddr, 32'h200);
      checkVal("drain_discard_valid", {31'h0, if_valid}, 32'h0);
      checkVal("drain_discard_addr", if_imemAddr, 32'h10);
      step();
      checkVal("br_fetch_valid", {31'h0, if_valid}, 32'h1);
      checkVal("br_fetch_addr", if_imemAddr, 32'h200);
      checkVal("br_fetch_pc", if_pc, 32'h204);

      // Stall with ihit for two cycles holds PC and latch
      setIn(1'b1, 2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step();
         checkVal($sformatf("stall%0d_pc", i), imemaddr, 32'h204);
         checkVal($sformatf("stall%0d_addr", i), if_imemAddr, 32'h200);
         checkVal($sformatf("stall%0d_valid", i), {31'h0, if_valid}, 32'h1);
      end
      // Jump while stalled: redirect wins
      jAddr = 32'h00000080;
      setIn(1'b1, 2'b10, 1'b1, 1'b0);
      step();
      checkVal("stall_jmp_pc", imemaddr, 32'h80);
      checkVal("stall_jmp_valid", {31'h0, if_valid}, 32'h0);

      // Newer redirect in DRAIN overwrites pending target
      brAddr = 32'h00000100;
      setIn(1'b0, 2'b01, 1'b0, 1'b0);
      step();
      jrAddr = 32'h00000301;
      setIn(1'b0, 2'b11, 1'b0, 1'b0);
      step();
      checkVal("drain2_addr", imemaddr, 32'h80);
      setIn(1'b1, 2'b00, 1'b0, 1'b0);
      step();
      checkVal("drain2_exit_pc", imemaddr, 32'h300);

      // Halt with simultaneous jump-register
      jrAddr = 32'h00000500;
      setIn(1'b1, 2'b11, 1'b0, 1'b1);
      step();
      checkVal("halt_ren", {31'h0, imemREN}, 32'h0);
      checkVal("halt_pc", imemaddr, 32'h300);
      checkVal("halt_valid", {31'h0, if_valid}, 32'h0);
      setIn(1'b1, 2'b00, 1'b0, 1'b0);
      step();
      checkVal("halted_stay_ren", {31'h0, imemREN}, 32'h0);
      checkVal("halted_stay_pc", imemaddr, 32'h300);

      // Asynchronous reset pulse leaves HALTED
      nRST = 1'b0;
      #2;
      checkVal("areset_pc", imemaddr, 32'h0);
      checkVal("areset_ren", {31'h0, imemREN}, 32'h1);
      nRST = 1'b1;
      step();
      checkVal("post_rst_valid", {31'h0, if_valid}, 32'h1);
      checkVal("post_rst_addr", if_imemAddr, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
